// File: rtl/dizi_algilayici_pkg.sv
// Shared types, constants and elaboration-time helpers for the serial
// pattern detector: state-index width, next-state table builder and the
// parameter legality check.
package dizi_algilayici_pkg;

  // Longest pattern the table layout can hold.
  localparam int MAKS_UZUNLUK = 16;
  // Bits needed for a state index 0..MAKS_UZUNLUK-1.
  localparam int DURUM_MAKS_W = 4;

  // One table entry: detect flag plus next matched-prefix length.
  typedef struct packed {
    logic                    tespit;
    logic [DURUM_MAKS_W-1:0] sonraki;
  } gecis_girdisi_t;

  localparam int GIRDI_W = $bits(gecis_girdisi_t);
  // Flat table: entry for (state k, bit b) sits at index 2*k+b.
  localparam int TABLO_W = MAKS_UZUNLUK * 2 * GIRDI_W;

  typedef logic [TABLO_W-1:0] gecis_tablosu_t;

  // Width of the state index: $clog2(N), never less than one bit.
  function automatic int durum_genislik(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Pattern length and counter width must be in range.
  function automatic bit parametre_gecerli(input int n, input int sayac_w);
    return (n >= 2) && (n <= MAKS_UZUNLUK) && (sayac_w >= 1);
  endfunction

  // Builds the next-state table [k][bit]. Pattern bit i in arrival order
  // is desen[n-1-i]. For each (k, bit) the received string is the matched
  // prefix of length k followed by bit; the next state is the longest
  // pattern prefix (shorter than n) that is a suffix of that string. When
  // the string is the whole pattern a detection is flagged and, for the
  // overlapping variant, this search naturally yields the longest proper
  // border; the non-overlapping variant restarts from empty instead.
  function automatic gecis_tablosu_t tablo_olustur(
    input logic [MAKS_UZUNLUK-1:0] desen,
    input int                      n,
    input bit                      ortusme
  );
    gecis_tablosu_t tablo;
    gecis_girdisi_t girdi;
    int             ust;
    int             en_uzun;
    int             j;
    bit             uyar;
    bit             tespit;
    bit             s_bit;
    tablo = '0;
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 2; b++) begin
        tespit  = (k == n - 1) && (desen[0] == b[0]);
        ust     = (k + 1 < n - 1) ? k + 1 : n - 1;
        en_uzun = 0;
        for (int l = ust; l > 0; l--) begin
          if (en_uzun == 0) begin
            uyar = 1'b1;
            for (int i = 0; i < l; i++) begin
              j     = k + 1 - l + i;
              s_bit = (j == k) ? b[0] : desen[n-1-j];
              if (desen[n-1-i] != s_bit) uyar = 1'b0;
            end
            if (uyar) en_uzun = l;
          end
        end
        if (tespit && !ortusme) en_uzun = 0;
        girdi.tespit  = tespit;
        girdi.sonraki = DURUM_MAKS_W'(en_uzun);
        tablo[(2*k+b)*GIRDI_W +: GIRDI_W] = girdi;
      end
    end
    return tablo;
  endfunction

endpackage

// File: rtl/dizi_algilayici_desen_gecis.sv
// Combinational lookup into the elaboration-time transition table:
// (current matched-prefix length, incoming bit) -> (next length, detect).
module desen_gecis
  import dizi_algilayici_pkg::*;
#(
  parameter int DW = 2
) (
  input  gecis_tablosu_t  i_tablo,
  input  logic [DW-1:0]   i_durum,
  input  logic            i_bit,
  output logic [DW-1:0]   o_sonraki,
  output logic            o_tespit
);

  // Row index 2*k+bit, with k widened to the table's fixed index width.
  logic [DURUM_MAKS_W:0] w_satir;

  assign w_satir   = {DURUM_MAKS_W'(i_durum), i_bit};
  // Next state fits in DW bits because stored states are always below N.
  assign o_sonraki = DW'(i_tablo[w_satir*GIRDI_W +: DURUM_MAKS_W]);
  assign o_tespit  = i_tablo[w_satir*GIRDI_W + DURUM_MAKS_W];

endmodule

// File: rtl/dizi_algilayici.sv
// Parametrised serial pattern detector. Tracks the longest pattern prefix
// that is a suffix of the qualified input stream (KMP automaton), emits a
// registered one-cycle pulse per detection and keeps a saturating count.
module dizi_algilayici
  import dizi_algilayici_pkg::*;
#(
  parameter int                       DESEN_UZUNLUK  = 4,
  parameter logic [DESEN_UZUNLUK-1:0] DESEN          = 4'b1011,
  parameter bit                       ORTUSME        = 1'b1,
  parameter int                       SAYAC_GENISLIK = 8
) (
  input  logic                                      saat,
  input  logic                                      reset,
  input  logic                                      giris,
  input  logic                                      gecerli,
  input  logic                                      temizle,
  output logic                                      bulundu,
  output logic [durum_genislik(DESEN_UZUNLUK)-1:0]  durum_no,
  output logic [SAYAC_GENISLIK-1:0]                 sayac
);

  localparam int DW = durum_genislik(DESEN_UZUNLUK);

  localparam gecis_tablosu_t TABLO =
    tablo_olustur(MAKS_UZUNLUK'(DESEN), DESEN_UZUNLUK, ORTUSME);

  if (!parametre_gecerli(DESEN_UZUNLUK, SAYAC_GENISLIK)) begin : g_parametre_hatasi
    $error("dizi_algilayici: DESEN_UZUNLUK=%0d must be 2..16, SAYAC_GENISLIK=%0d must be >=1",
           DESEN_UZUNLUK, SAYAC_GENISLIK);
  end

  logic [DW-1:0]             r_durum;
  logic                      r_bulundu;
  logic [SAYAC_GENISLIK-1:0] r_sayac;

  logic [DW-1:0]             w_tablo_sonraki;
  logic                      w_tablo_tespit;
  logic                      w_tespit;
  logic [DW-1:0]             w_durum_sonraki;
  logic [SAYAC_GENISLIK-1:0] w_sayac_sonraki;

  desen_gecis #(
    .DW (DW)
  ) u_gecis (
    .i_tablo   (TABLO),
    .i_durum   (r_durum),
    .i_bit     (giris),
    .o_sonraki (w_tablo_sonraki),
    .o_tespit  (w_tablo_tespit)
  );

  // A detection only counts on an edge where the bit is actually sampled.
  assign w_tespit = gecerli & w_tablo_tespit;

  // Next matched-prefix length: advance on a valid bit, otherwise hold.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value unassigned and infers a latch.
    w_durum_sonraki = r_durum;
    if (gecerli) w_durum_sonraki = w_tablo_sonraki;
  end

  // Next counter value: clear wins over hold, a same-edge detection after
  // a clear leaves one, otherwise count up and stick at all-ones.
  always_comb begin
    w_sayac_sonraki = r_sayac;
    if (temizle) begin
      w_sayac_sonraki = w_tespit ? SAYAC_GENISLIK'(1) : '0;
    end else if (w_tespit && !(&r_sayac)) begin
      w_sayac_sonraki = r_sayac + SAYAC_GENISLIK'(1);
    end
  end

  // State, pulse and counter registers; synchronous reset overrides all.
  always_ff @(posedge saat) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values; all three are small flops, so each gets a reset.
    if (reset) begin
      r_durum   <= '0;
      r_bulundu <= 1'b0;
      r_sayac   <= '0;
    end else begin
      r_durum   <= w_durum_sonraki;
      r_bulundu <= w_tespit;
      r_sayac   <= w_sayac_sonraki;
    end
  end

  assign durum_no = r_durum;
  assign bulundu  = r_bulundu;
  assign sayac    = r_sayac;

endmodule

// File: tb/tb_dizi_algilayici.sv
// Self-checking bench for dizi_algilayici. Three instances share one input
// stream: defaults (overlap, 8-bit counter), non-overlapping, and overlap
// with a 2-bit counter. A history-based reference model recomputes the
// expected outputs from the pattern-matching rules after every edge.
module tb_dizi_algilayici;

  localparam int            N        = 4;
  localparam logic [N-1:0]  DESEN_TB = 4'b1011;

  logic       saat    = 1'b0;
  logic       reset   = 1'b0;
  logic       giris   = 1'b0;
  logic       gecerli = 1'b0;
  logic       temizle = 1'b0;

  logic       ov_bulundu, no_bulundu, c2_bulundu;
  logic [1:0] ov_durum,   no_durum,   c2_durum;
  logic [7:0] ov_sayac,   no_sayac;
  logic [1:0] c2_sayac;

  int n_vec = 0;
  int n_err = 0;
  int adim_no = 0;

  // Reference model state: recent valid bits per matching mode.
  bit h_ov[$];
  bit h_no[$];
  int cnt_ov, cnt_no, cnt_c2;
  bit bek_ov, bek_no;

  always #5 saat = ~saat;

  dizi_algilayici dut_ov (
    .saat(saat), .reset(reset), .giris(giris), .gecerli(gecerli), .temizle(temizle),
    .bulundu(ov_bulundu), .durum_no(ov_durum), .sayac(ov_sayac)
  );

  dizi_algilayici #(.ORTUSME(1'b0)) dut_no (
    .saat(saat), .reset(reset), .giris(giris), .gecerli(gecerli), .temizle(temizle),
    .bulundu(no_bulundu), .durum_no(no_durum), .sayac(no_sayac)
  );

  dizi_algilayici #(.SAYAC_GENISLIK(2)) dut_c2 (
    .saat(saat), .reset(reset), .giris(giris), .gecerli(gecerli), .temizle(temizle),
    .bulundu(c2_bulundu), .durum_no(c2_durum), .sayac(c2_sayac)
  );

  function automatic bit pat(input int i);
    return DESEN_TB[N-1-i];
  endfunction

  // Longest pattern prefix shorter than N that ends the history.
  function automatic int onek(input bit h[$]);
    int en;
    bit ok;
    en = 0;
    for (int l = 1; l <= N - 1; l++) begin
      if (l <= h.size()) begin
        ok = 1'b1;
        for (int i = 0; i < l; i++)
          if (h[h.size()-l+i] != pat(i)) ok = 1'b0;
        if (ok) en = l;
      end
    end
    return en;
  endfunction

  // True when the last N bits of the history are the whole pattern.
  function automatic bit tam(input bit h[$]);
    bit ok;
    if (h.size() < N) return 1'b0;
    ok = 1'b1;
    for (int i = 0; i < N; i++)
      if (h[h.size()-N+i] != pat(i)) ok = 1'b0;
    return ok;
  endfunction

  function automatic int say(input int c, input bit det, input bit t, input int maks);
    if (t) return det ? 1 : 0;
    if (det && c < maks) return c + 1;
    return c;
  endfunction

  task automatic model_guncelle(input bit b, input bit v, input bit t, input bit r);
    if (r) begin
      h_ov.delete();
      h_no.delete();
      cnt_ov = 0; cnt_no = 0; cnt_c2 = 0;
      bek_ov = 1'b0; bek_no = 1'b0;
    end else begin
      bek_ov = 1'b0;
      bek_no = 1'b0;
      if (v) begin
        h_ov.push_back(b);
        h_no.push_back(b);
        bek_ov = tam(h_ov);
        bek_no = tam(h_no);
        if (bek_no) h_no.delete();
        while (h_ov.size() > N - 1) h_ov.delete(0);
        while (h_no.size() > N - 1) h_no.delete(0);
      end
      cnt_ov = say(cnt_ov, bek_ov, t, 255);
      cnt_no = say(cnt_no, bek_no, t, 255);
      cnt_c2 = say(cnt_c2, bek_ov, t, 3);
    end
  endtask

  // Apply one clock of stimulus, then compare all three instances to the model.
  task automatic adim(input bit b, input bit v, input bit t, input bit r);
    logic [1:0] d_ov, d_no;
    giris = b; gecerli = v; temizle = t; reset = r;
    @(posedge saat);
    #1;
    adim_no++;
    model_guncelle(b, v, t, r);
    d_ov = 2'(onek(h_ov));
    d_no = 2'(onek(h_no));
    n_vec++;
    if (ov_bulundu !== bek_ov) begin
      n_err++; $display("FAIL ov_bulundu step %0d: got %b want %b", adim_no, ov_bulundu, bek_ov);
    end
    n_vec++;
    if (ov_durum !== d_ov) begin
      n_err++; $display("FAIL ov_durum_no step %0d: got %0d want %0d", adim_no, ov_durum, d_ov);
    end
    n_vec++;
    if (ov_sayac !== 8'(cnt_ov)) begin
      n_err++; $display("FAIL ov_sayac step %0d: got %0d want %0d", adim_no, ov_sayac, cnt_ov);
    end
    n_vec++;
    if (no_bulundu !== bek_no) begin
      n_err++; $display("FAIL no_bulundu step %0d: got %b want %b", adim_no, no_bulundu, bek_no);
    end
    n_vec++;
    if (no_durum !== d_no) begin
      n_err++; $display("FAIL no_durum_no step %0d: got %0d want %0d", adim_no, no_durum, d_no);
    end
    n_vec++;
    if (no_sayac !== 8'(cnt_no)) begin
      n_err++; $display("FAIL no_sayac step %0d: got %0d want %0d", adim_no, no_sayac, cnt_no);
    end
    n_vec++;
    if (c2_bulundu !== bek_ov) begin
      n_err++; $display("FAIL c2_bulundu step %0d: got %b want %b", adim_no, c2_bulundu, bek_ov);
    end
    n_vec++;
    if (c2_durum !== d_ov) begin
      n_err++; $display("FAIL c2_durum_no step %0d: got %0d want %0d", adim_no, c2_durum, d_ov);
    end
    n_vec++;
    if (c2_sayac !== 2'(cnt_c2)) begin
      n_err++; $display("FAIL c2_sayac step %0d: got %0d want %0d", adim_no, c2_sayac, cnt_c2);
    end
  endtask

  task automatic sifirla();
    adim(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    adim(1'b1, 1'b1, 1'b0, 1'b1);
    adim(1'b0, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if ({ov_bulundu, ov_durum, ov_sayac} !== 11'd0) begin
      n_err++; $display("FAIL reset_state: got %b/%0d/%0d want 0/0/0", ov_bulundu, ov_durum, ov_sayac);
    end
  endtask

  task automatic test_overlap();
    bit         akis[7] = '{1, 0, 1, 1, 0, 1, 1};
    logic [6:0] p_ov, p_no;
    sifirla();
    p_ov = '0; p_no = '0;
    for (int i = 0; i < 7; i++) begin
      adim(akis[i], 1'b1, 1'b0, 1'b0);
      p_ov[i] = ov_bulundu;
      p_no[i] = no_bulundu;
      if (i == 3) begin
        n_vec++;
        if (ov_durum !== 2'd1) begin
          n_err++; $display("FAIL overlap_durum_after_4: got %0d want 1", ov_durum);
        end
      end
    end
    n_vec++;
    if (p_ov !== 7'b1001000) begin
      n_err++; $display("FAIL overlap_pulses: got %b want 1001000", p_ov);
    end
    n_vec++;
    if (ov_sayac !== 8'd2) begin
      n_err++; $display("FAIL overlap_sayac: got %0d want 2", ov_sayac);
    end
    n_vec++;
    if (p_no !== 7'b0001000) begin
      n_err++; $display("FAIL nooverlap_pulses: got %b want 0001000", p_no);
    end
    n_vec++;
    if (no_sayac !== 8'd1 || no_durum !== 2'd1) begin
      n_err++; $display("FAIL nooverlap_end: got sayac %0d durum %0d want 1 1", no_sayac, no_durum);
    end
  endtask

  task automatic test_fallback();
    bit         akis[6]  = '{1, 0, 1, 0, 1, 1};
    logic [1:0] durum_b[5] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
    logic [5:0] p;
    sifirla();
    p = '0;
    for (int i = 0; i < 6; i++) begin
      adim(akis[i], 1'b1, 1'b0, 1'b0);
      p[i] = ov_bulundu;
      if (i < 5) begin
        n_vec++;
        if (ov_durum !== durum_b[i]) begin
          n_err++; $display("FAIL fallback_durum bit %0d: got %0d want %0d", i + 1, ov_durum, durum_b[i]);
        end
      end
    end
    n_vec++;
    if (p !== 6'b100000) begin
      n_err++; $display("FAIL fallback_pulses: got %b want 100000", p);
    end
  endtask

  task automatic test_valid_gaps();
    int darbe;
    sifirla();
    darbe = 0;
    adim(1'b1, 1'b1, 1'b0, 1'b0);
    adim(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      adim(i[0], 1'b0, 1'b0, 1'b0);
      if (ov_bulundu) darbe++;
      n_vec++;
      if (ov_durum !== 2'd2) begin
        n_err++; $display("FAIL gap_hold cycle %0d: got %0d want 2", i, ov_durum);
      end
    end
    adim(1'b1, 1'b1, 1'b0, 1'b0);
    if (ov_bulundu) darbe++;
    adim(1'b1, 1'b1, 1'b0, 1'b0);
    if (ov_bulundu) darbe++;
    n_vec++;
    if (darbe != 1 || ov_bulundu !== 1'b1) begin
      n_err++; $display("FAIL gap_pulses: got %0d (last %b) want 1 (last 1)", darbe, ov_bulundu);
    end
  endtask

  task automatic test_counter();
    bit bas[4] = '{1, 0, 1, 1};
    bit dev[3] = '{0, 1, 1};
    sifirla();
    for (int i = 0; i < 4; i++) adim(bas[i], 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 3; i++) adim(dev[i], 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (c2_sayac !== 2'd3) begin
      n_err++; $display("FAIL counter_saturate: got %0d want 3", c2_sayac);
    end
    adim(1'b0, 1'b1, 1'b0, 1'b0);
    adim(1'b1, 1'b1, 1'b0, 1'b0);
    adim(1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (c2_sayac !== 2'd1 || c2_bulundu !== 1'b1) begin
      n_err++; $display("FAIL counter_clear_with_detect: got %0d/%b want 1/1", c2_sayac, c2_bulundu);
    end
    adim(1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (c2_sayac !== 2'd0) begin
      n_err++; $display("FAIL counter_clear: got %0d want 0", c2_sayac);
    end
  endtask

  task automatic test_saturation();
    bit bas[4] = '{1, 0, 1, 1};
    bit dev[3] = '{0, 1, 1};
    sifirla();
    for (int i = 0; i < 4; i++) adim(bas[i], 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 300; r++)
      for (int i = 0; i < 3; i++) adim(dev[i], 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (ov_sayac !== 8'hFF) begin
      n_err++; $display("FAIL sayac8_saturate: got %0d want 255", ov_sayac);
    end
  endtask

  task automatic test_reset_mid();
    sifirla();
    adim(1'b1, 1'b1, 1'b0, 1'b0);
    adim(1'b0, 1'b1, 1'b0, 1'b0);
    adim(1'b1, 1'b1, 1'b0, 1'b0);
    adim(1'b1, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if ({ov_bulundu, ov_durum, ov_sayac} !== 11'd0) begin
      n_err++; $display("FAIL reset_mid_cleared: got %b/%0d/%0d want 0/0/0", ov_bulundu, ov_durum, ov_sayac);
    end
    adim(1'b1, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (ov_durum !== 2'd1 || ov_bulundu !== 1'b0 || ov_sayac !== 8'd0) begin
      n_err++; $display("FAIL reset_mid_after: got %0d/%b/%0d want 1/0/0", ov_durum, ov_bulundu, ov_sayac);
    end
  endtask

  task automatic test_random();
    bit b, v, t, r;
    sifirla();
    for (int i = 0; i < 3000; i++) begin
      b = 1'($urandom);
      v = ($urandom_range(0, 9) < 8);
      t = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 99) == 0);
      adim(b, v, t, r);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_fallback();
    test_valid_gaps();
    test_counter();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dizi_algilayici.md
# dizi_algilayici

Parametrised serial pattern-detector FSM. It generalises the fixed 4-state lab machine to an N-bit pattern chosen at elaboration, with optional overlapping matches, an input-valid qualifier, a current-match-length output and a saturating detection counter. It sits between a serial bit source and lab display/LED logic.

## Interface
- `DESEN_UZUNLUK`, default 4: pattern length N, legal range 2..16.
- `DESEN`, default 4'b1011: pattern, `DESEN_UZUNLUK` bits, MSB received first.
- `ORTUSME`, default 1: 1 lets a match reuse its own suffix; 0 restarts from empty after a match.
- `SAYAC_GENISLIK`, default 8: width of the detection counter.
- `saat` input 1: clock, all state updates on the rising edge.
- `reset` input 1: reset, synchronous, active-high.
- `giris` input 1: serial data bit.
- `gecerli` input 1: `giris` is sampled only when this is 1.
- `temizle` input 1: synchronous clear of `sayac` only.
- `bulundu` output 1: registered one-cycle detection pulse.
- `durum_no` output $clog2(N): current matched-prefix length 0..N-1.
- `sayac` output `SAYAC_GENISLIK`: saturating count of detections.

## Operation
- State k ∈ 0..N-1 is the length of the longest pattern prefix that is a suffix of the valid bits received so far. State N is never stored.
- Expected bit in state k is `DESEN[N-1-k]`.
- On an edge with `gecerli`=1:
  - bit matches and k+1<N → k+1.
  - bit matches and k+1=N → detection. Next state is f(N) if `ORTUSME`=1, else 0. f(N) is the longest proper border of the pattern.
  - mismatch → next state is the longest prefix that is a suffix of (matched prefix, bit). This is the KMP fallback and is not simply 0.
- On an edge with `gecerli`=0: state holds, no detection.
- `bulundu` is 1 for exactly the cycle following a detecting edge, otherwise 0. Back-to-back detections produce back-to-back pulses.
- `sayac` increments on each detection and saturates at 2^`SAYAC_GENISLIK`-1.
- `temizle` alone sets `sayac` to 0. `temizle` together with a detection on the same edge sets `sayac` to 1.
- `reset` has priority over everything. All of `durum_no`, `bulundu` and `sayac` go to 0 on the next edge, including mid-pattern. The power-up initial value is also 0.
- Illegal `DESEN_UZUNLUK` values stop elaboration with an error.

## Timing
- Every output is a register. There is no combinational path from input to output.
- Detection latency: the edge that samples the final pattern bit sets `bulundu` high. `sayac` updates on that same edge.
- `durum_no` reflects the bits sampled up to and including the previous edge.
- Throughput is one bit per cycle when `gecerli` is held at 1.

## Structure
- A shared package holds:
  - the state-index width function ($clog2 of N, minimum 1);
  - a constant function that builds the next-state table [k][bit] from `DESEN`, `DESEN_UZUNLUK` and `ORTUSME`, evaluated at elaboration;
  - the parameter-legality check.
- Optional sub-module `desen_gecis`: the combinational lookup from table, k and bit to next k plus a detect flag. The top level keeps the state register, pulse register and counter.

## Test plan
All scenarios use the defaults: N=4, `DESEN`=1011, `gecerli`=1 unless noted.

- **Overlap:** stream 1,0,1,1,0,1,1 → `bulundu` pulses after bit 4 and after bit 7; `sayac`=2; `durum_no` after bit 4 is 1.
- **No overlap (`ORTUSME`=0):** same stream → one pulse after bit 4 only; `sayac`=1; `durum_no` after bit 7 is 1.
- **Fallback:** stream 1,0,1,0,1,1 → `durum_no` sequence 1,2,3,2,3, then a pulse after bit 6.
- **Valid gaps:** 1,0, then three cycles with `gecerli`=0 and `giris` toggling, then 1,1 → `durum_no` holds 2 through the gap; exactly one pulse.
- **Counter (`SAYAC_GENISLIK`=2):**
  - 4 detections → `sayac` stays at 3.
  - `temizle` on the same edge as the 5th detection → `sayac`=1.
  - `temizle` alone → `sayac`=0.
- **Reset mid-pattern:** 1,0,1, then `reset` for one cycle, then 1 → `durum_no`=0 after reset and 1 afterwards; no `bulundu`; `sayac`=0.
